// File: rtl/ps2_key_pkg.sv
// Shared scan-code set 2 constants, move encodings, key_held bit map and prefix FSM states
// for the PS/2 key decoder.
package ps2_key_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ENTER = 4;
    localparam int KEY_ESC   = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } pfx_state_e;

    typedef struct packed {
        logic vld;
        dir_e dir;
    } move_evt_t;

    // At most one bit is set; an empty vector maps to up and is never used.
    function automatic dir_e dir_from_onehot(input logic [3:0] oh);
        dir_e d;
        d = DIR_UP;
        if (oh[KEY_DOWN])  d = DIR_DOWN;
        if (oh[KEY_LEFT])  d = DIR_LEFT;
        if (oh[KEY_RIGHT]) d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/ps2_key_repeat_timer.sv
// Auto-repeat counter: arm loads the initial delay, then fires every period until stopped.
// A delay of zero keeps the timer permanently idle.
module ps2_key_repeat_timer
    import ps2_key_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic arm,
    input  dir_e arm_dir,
    input  logic stop,
    output logic fire,
    output logic active,
    output dir_e dir
);

    localparam int MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = (MAXV < 2) ? 1 : $clog2(MAXV + 1);
    // Counter holds edges-remaining minus one, so the first repeat becomes visible
    // exactly REPEAT_DELAY cycles after the make strobe.
    localparam logic [CW-1:0] DLY_LOAD = CW'((REPEAT_DELAY >= 2) ? REPEAT_DELAY - 2 : 0);
    localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] cnt;

    assign fire = active && (cnt == '0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            active <= 1'b0;
            dir    <= DIR_UP;
            cnt    <= '0;
        end else if (arm && REPEAT_DELAY != 0) begin
            active <= 1'b1;
            dir    <= arm_dir;
            cnt    <= DLY_LOAD;
        end else if (stop) begin
            active <= 1'b0;
        end else if (active) begin
            cnt <= (cnt == '0) ? PER_LOAD : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 decoder: prefix FSM, held-key tracking, typematic suppression,
// auto-repeat and a 1-deep move event register. `PS2_KEY_WASD_EN adds W/A/S/D aliases.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 10_000_000,
    parameter int PREFIX_TIMEOUT = 5_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       move_overflow,
    output logic [5:0] key_held,
    output logic       enter_pulse,
    output logic       esc_pulse,
    output logic [7:0] last_scancode
);

    localparam int TW = (PREFIX_TIMEOUT < 2) ? 1 : $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'((PREFIX_TIMEOUT > 0) ? PREFIX_TIMEOUT - 1 : 0);

    pfx_state_e st;
    logic [TW-1:0] idle_cnt;

    logic [3:0] arrow_held, let_held;
    logic       ent_held, esc_held;
    move_evt_t  hold;

    logic       byte_ok, is_e0, is_f0, code_done, ext, brk, mk, bk;
    logic [3:0] arrow_hit, let_hit, dir_hit;
    logic [3:0] arrow_nxt, let_nxt, dir_held_nxt;
    logic       ent_hit, esc_hit, dec_ev, rep_ev, rep_stop, accept;
    dir_e       dec_dir;

    logic rep_fire, rep_active;
    dir_e rep_dir;

    always_comb begin
        byte_ok   = received_data_en && !(received_data == SC_BAT ||
                    received_data == SC_ACK || received_data == SC_RESEND);
        is_e0     = received_data == SC_E0;
        is_f0     = received_data == SC_F0;
        code_done = byte_ok && !(st == ST_IDLE && (is_e0 || is_f0))
                            && !(st == ST_E0 && is_f0);
        ext       = (st == ST_E0) || (st == ST_E0F0);
        brk       = (st == ST_F0) || (st == ST_E0F0);
        mk        = code_done && !brk;
        bk        = code_done && brk;

        arrow_hit = {ext && received_data == SC_RIGHT, ext && received_data == SC_LEFT,
                     ext && received_data == SC_DOWN,  ext && received_data == SC_UP};
`ifdef PS2_KEY_WASD_EN
        let_hit   = {!ext && received_data == SC_D, !ext && received_data == SC_A,
                     !ext && received_data == SC_S, !ext && received_data == SC_W};
`else
        let_hit   = '0;
`endif
        ent_hit   = !ext && received_data == SC_ENTER;
        esc_hit   = !ext && received_data == SC_ESC;
        dir_hit   = arrow_hit | let_hit;

        arrow_nxt = arrow_held;
        let_nxt   = let_held;
        if (mk) begin
            arrow_nxt = arrow_held | arrow_hit;
            let_nxt   = let_held | let_hit;
        end else if (bk) begin
            arrow_nxt = arrow_held & ~arrow_hit;
            let_nxt   = let_held & ~let_hit;
        end
        dir_held_nxt = arrow_nxt | let_nxt;

        // A make of a source that is already down is keyboard typematic: ignore it.
        dec_ev   = mk && ((|(arrow_hit & ~arrow_held)) || (|(let_hit & ~let_held)));
        dec_dir  = dir_from_onehot(dir_hit);
        rep_stop = rep_active && !dir_held_nxt[rep_dir];
        rep_ev   = rep_fire && !rep_stop;
        accept   = hold.vld && move_ready;
    end

    ps2_key_repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_rep (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .arm     (dec_ev),
        .arm_dir (dec_dir),
        .stop    (rep_stop),
        .fire    (rep_fire),
        .active  (rep_active),
        .dir     (rep_dir)
    );

    // Prefix FSM; a stalled prefix falls back to IDLE and the partial code is lost.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            st       <= ST_IDLE;
            idle_cnt <= '0;
        end else if (byte_ok) begin
            idle_cnt <= '0;
            case (st)
                ST_IDLE: st <= is_e0 ? ST_E0 : (is_f0 ? ST_F0 : ST_IDLE);
                ST_E0:   st <= is_f0 ? ST_E0F0 : ST_IDLE;
                default: st <= ST_IDLE;
            endcase
        end else if (st != ST_IDLE) begin
            if (idle_cnt == TO_LAST) begin
                st       <= ST_IDLE;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            arrow_held    <= '0;
            let_held      <= '0;
            ent_held      <= 1'b0;
            esc_held      <= 1'b0;
            enter_pulse   <= 1'b0;
            esc_pulse     <= 1'b0;
            last_scancode <= '0;
            hold          <= '0;
            move_overflow <= 1'b0;
        end else begin
            arrow_held  <= arrow_nxt;
            let_held    <= let_nxt;
            enter_pulse <= mk && ent_hit && !ent_held;
            esc_pulse   <= mk && esc_hit && !esc_held;
            if (code_done) last_scancode <= received_data;
            if (mk && ent_hit) ent_held <= 1'b1;
            else if (bk && ent_hit) ent_held <= 1'b0;
            if (mk && esc_hit) esc_held <= 1'b1;
            else if (bk && esc_hit) esc_held <= 1'b0;

            // Decoded event has priority over a coincident repeat tick.
            if (dec_ev || rep_ev) begin
                if (!hold.vld || accept) begin
                    hold.vld <= 1'b1;
                    hold.dir <= dec_ev ? dec_dir : rep_dir;
                end else begin
                    move_overflow <= 1'b1;
                end
            end else if (accept) begin
                hold.vld <= 1'b0;
            end
        end
    end

    assign move_valid = hold.vld;
    assign move_dir   = hold.dir;
    assign key_held   = {esc_held, ent_held, arrow_held | let_held};

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: prefixes, holding register, typematic, timeout,
// reset mid-sequence and auto-repeat timing (REPEAT_DELAY=100, REPEAT_PERIOD=20).
module tb_ps2_key_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       move_ready = 1'b1;
    logic       move_valid, move_overflow, enter_pulse, esc_pulse;
    logic [1:0] move_dir;
    logic [5:0] key_held;
    logic [7:0] last_scancode;

    int n_chk = 0;
    int n_err = 0;
    int ent_cnt = 0;

    ps2_key_decoder #(
        .REPEAT_DELAY  (100),
        .REPEAT_PERIOD (20),
        .PREFIX_TIMEOUT(50)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .move_ready      (move_ready),
        .move_valid      (move_valid),
        .move_dir        (move_dir),
        .move_overflow   (move_overflow),
        .key_held        (key_held),
        .enter_pulse     (enter_pulse),
        .esc_pulse       (esc_pulse),
        .last_scancode   (last_scancode)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (enter_pulse) ent_cnt <= ent_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one byte; returns at the negedge after the sampling edge ("+1").
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        int hits[$];
        int exp_t[4];
        int cnt;
        logic bad_dir;
        exp_t = '{1, 100, 120, 140};

        idle(3);
        reset = 1'b0;
        chk("reset_state", {move_valid, move_dir, move_overflow, key_held,
                            enter_pulse, esc_pulse, last_scancode}, 32'h0);

        // Up arrow make and break
        send(8'hE0); send(8'h75);
        chk("up_valid", move_valid, 1);
        chk("up_dir", move_dir, 2'b00);
        chk("up_held", key_held, 6'b000001);
        idle(1);
        chk("up_accepted", move_valid, 0);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_brk_held", key_held, 6'b000000);
        chk("up_brk_noevt", move_valid, 0);

        // Holding register full, second event dropped
        move_ready = 1'b0;
        send(8'hE0); send(8'h6B);
        chk("hold_valid", move_valid, 1);
        chk("hold_dir_left", move_dir, 2'b10);
        send(8'hE0); send(8'h74);
        chk("hold_dir_kept", move_dir, 2'b10);
        chk("hold_overflow", move_overflow, 1);
        chk("hold_held_lr", key_held, 6'b001100);
        move_ready = 1'b1;
        idle(1);
        chk("hold_drained", move_valid, 0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("hold_released", key_held, 6'b000000);

        // Reset between E0 and 75
        send(8'hE0); send(8'h75);
        idle(1);
        send(8'hE0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send(8'h75);
        chk("rst_noevt", move_valid, 0);
        chk("rst_held", key_held, 6'b000000);
        chk("rst_ovf", move_overflow, 0);
        chk("rst_last", last_scancode, 8'h75);

        // Typematic suppression on Enter, Esc pulse
        send(8'h5A);
        chk("ent_pulse", enter_pulse, 1);
        send(8'h5A); send(8'h5A);
        idle(2);
        chk("ent_one_pulse", ent_cnt, 1);
        chk("ent_held", key_held, 6'b010000);
        send(8'hF0); send(8'h5A); send(8'h5A);
        idle(2);
        chk("ent_second", ent_cnt, 2);
        send(8'hF0); send(8'h5A);
        send(8'h76);
        chk("esc_pulse", esc_pulse, 1);
        chk("esc_held", key_held, 6'b100000);
        idle(1);
        chk("esc_pulse_end", esc_pulse, 0);
        send(8'hF0); send(8'h76);

        // Prefix timeout discards the pending E0
        send(8'hE0);
        idle(60);
        send(8'h75);
        chk("to_noevt", move_valid, 0);
        chk("to_held", key_held, 6'b000000);
        chk("to_last", last_scancode, 8'h75);
        send(8'hE0);
        idle(40);
        send(8'h75);
        chk("to_short_evt", move_valid, 1);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Controller bytes ignored
        send(8'h15); send(8'hFE); send(8'hAA);
        chk("ignored_last", last_scancode, 8'h15);

        // Auto-repeat timing while holding right
        bad_dir = 1'b0;
        send(8'hE0); send(8'h74);
        if (move_valid) hits.push_back(1);
        for (int n = 2; n <= 145; n++) begin
            @(negedge CLOCK_50);
            if (move_valid) begin
                hits.push_back(n);
                if (move_dir !== 2'b11) bad_dir = 1'b1;
            end
        end
        chk("rep_count", hits.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rep_t%0d", i), (i < hits.size()) ? hits[i] : -1, exp_t[i]);
        chk("rep_dir", bad_dir, 0);
        send(8'hE0); send(8'hF0); send(8'h74);
        cnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLOCK_50);
            if (move_valid) cnt++;
        end
        chk("rep_after_brk", cnt, 0);

        // W alias
        send(8'h1D);
`ifdef PS2_KEY_WASD_EN
        chk("wasd_valid", move_valid, 1);
        chk("wasd_dir", move_dir, 2'b00);
        send(8'hF0); send(8'h1D);
`else
        chk("wasd_unmapped", move_valid, 0);
        chk("wasd_last", last_scancode, 8'h1D);
`endif

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
